// File: rtl/ws2812_rx_decoder.sv
// WS2812 single-wire receiver: measures synchronized high-pulse widths to recover
// GRB pixel words, their index within the frame, and latch (frame end) events.
module ws2812_rx_decoder #(
    parameter int NUM_LEDS        = 8,
    parameter int SYSTEM_CLOCK    = 50000000,
    parameter int T_BIT_THRESH_NS = 600,
    parameter int T_HIGH_MAX_NS   = 2000,
    parameter int T_RESET_NS      = 50000
) (
    input  logic                          CLK,
    input  logic                          RESET_N,
    input  logic                          DIN,
    output logic                          PIX_VALID,
    output logic [23:0]                   PIX_DATA,
    output logic [$clog2(NUM_LEDS)-1:0]   PIX_ADDR,
    output logic                          FRAME_DONE,
    output logic [$clog2(NUM_LEDS):0]     PIX_COUNT,
    output logic                          OVERFLOW,
    output logic                          ERROR
);

    localparam int CYC_US = SYSTEM_CLOCK / 1000000;
    localparam int C_BIT  = CYC_US * T_BIT_THRESH_NS / 1000;
    localparam int C_HMAX = CYC_US * T_HIGH_MAX_NS / 1000;
    localparam int C_RST  = CYC_US * T_RESET_NS / 1000;
    localparam int CW     = $clog2(C_RST + 2);
    localparam int AW     = $clog2(NUM_LEDS);

    localparam logic [CW-1:0] K_BIT  = CW'(C_BIT);
    localparam logic [CW-1:0] K_HMAX = CW'(C_HMAX);
    localparam logic [CW-1:0] K_RST  = CW'(C_RST);
    localparam logic [AW:0]   K_LEDS = (AW + 1)'(NUM_LEDS);

    typedef enum logic [1:0] {SYNC, IDLE, HIGH} state_t;

    logic          din_m, din_s, din_d;
    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt, cnt_inc;
    logic [4:0]    bit_cnt, bit_cnt_nxt;
    logic [23:0]   shift, shift_nxt;
    logic          seen, seen_nxt;
    logic          bit_val;
    logic          word_q, word_nxt;
    logic          latch_q, latch_nxt;
    logic          err_q, err_nxt;
    logic          abort_q, abort_nxt;
    logic [AW:0]   pix_cnt;
    logic          rise, fall;

    assign rise = din_s & ~din_d;
    assign fall = ~din_s & din_d;

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            din_m   <= 1'b0;
            din_s   <= 1'b0;
            din_d   <= 1'b0;
            state   <= SYNC;
            cnt     <= '0;
            bit_cnt <= '0;
            shift   <= '0;
            seen    <= 1'b0;
            word_q  <= 1'b0;
            latch_q <= 1'b0;
            err_q   <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            din_m   <= DIN;
            din_s   <= din_m;
            din_d   <= din_s;
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            bit_cnt <= bit_cnt_nxt;
            shift   <= shift_nxt;
            seen    <= seen_nxt;
            word_q  <= word_nxt;
            latch_q <= latch_nxt;
            err_q   <= err_nxt;
            abort_q <= abort_nxt;
        end
    end

    // One counter serves all states; it restarts at 1 on each edge so it counts
    // the edge cycle itself as the first cycle of the new level.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        bit_cnt_nxt = bit_cnt;
        shift_nxt   = shift;
        seen_nxt    = seen;
        word_nxt    = 1'b0;
        latch_nxt   = 1'b0;
        err_nxt     = 1'b0;
        abort_nxt   = 1'b0;
        bit_val     = 1'b0;
        cnt_inc     = (cnt == K_RST) ? cnt : cnt + 1'b1;
        case (state)
            SYNC: begin
                if (din_s) begin
                    cnt_nxt = '0;
                end else begin
                    cnt_nxt = cnt_inc;
                    if (cnt_inc == K_RST) state_nxt = IDLE;
                end
            end
            IDLE: begin
                if (rise) begin
                    cnt_nxt   = {{(CW-1){1'b0}}, 1'b1};
                    state_nxt = HIGH;
                end else begin
                    cnt_nxt = cnt_inc;
                    if (cnt_inc == K_RST && cnt != K_RST && seen) begin
                        latch_nxt   = 1'b1;
                        err_nxt     = (bit_cnt != 5'd0);
                        bit_cnt_nxt = '0;
                        seen_nxt    = 1'b0;
                    end
                end
            end
            HIGH: begin
                if (fall) begin
                    bit_val   = (cnt >= K_BIT);
                    shift_nxt = {shift[22:0], bit_val};
                    seen_nxt  = 1'b1;
                    cnt_nxt   = {{(CW-1){1'b0}}, 1'b1};
                    state_nxt = IDLE;
                    if (bit_cnt == 5'd23) begin
                        bit_cnt_nxt = '0;
                        word_nxt    = 1'b1;
                    end else begin
                        bit_cnt_nxt = bit_cnt + 5'd1;
                    end
                end else begin
                    cnt_nxt = cnt_inc;
                    if (cnt_inc > K_HMAX) begin
                        err_nxt     = 1'b1;
                        abort_nxt   = 1'b1;
                        bit_cnt_nxt = '0;
                        seen_nxt    = 1'b0;
                        cnt_nxt     = '0;
                        state_nxt   = SYNC;
                    end
                end
            end
            default: state_nxt = SYNC;
        endcase
    end

    // PIX_VALID is a one-cycle strobe with no back-pressure: the consumer must take
    // PIX_DATA/PIX_ADDR in the cycle it is high.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            PIX_VALID  <= 1'b0;
            PIX_DATA   <= '0;
            PIX_ADDR   <= '0;
            FRAME_DONE <= 1'b0;
            PIX_COUNT  <= '0;
            OVERFLOW   <= 1'b0;
            ERROR      <= 1'b0;
            pix_cnt    <= '0;
        end else begin
            PIX_VALID  <= 1'b0;
            FRAME_DONE <= 1'b0;
            ERROR      <= err_q;
            if (FRAME_DONE) OVERFLOW <= 1'b0;
            if (word_q) begin
                if (pix_cnt < K_LEDS) begin
                    PIX_VALID <= 1'b1;
                    PIX_DATA  <= shift;
                    PIX_ADDR  <= pix_cnt[AW-1:0];
                    pix_cnt   <= pix_cnt + 1'b1;
                end else begin
                    OVERFLOW <= 1'b1;
                end
            end
            if (latch_q) begin
                FRAME_DONE <= 1'b1;
                PIX_COUNT  <= pix_cnt;
                pix_cnt    <= '0;
            end
            if (abort_q) pix_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_ws2812_rx_decoder.sv
// Directed bench for ws2812_rx_decoder: drives NRZ waveforms on DIN and checks
// pixel strobes, latency, latch boundaries, errors and overflow.
module tb_ws2812_rx_decoder;
  localparam int N  = 8;
  localparam int AW = $clog2(N);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          din = 1'b0;
  logic          pix_valid;
  logic [23:0]   pix_data;
  logic [AW-1:0] pix_addr;
  logic          frame_done;
  logic [AW:0]   pix_count;
  logic          overflow;
  logic          error;

  int unsigned cyc = 0;
  int unsigned last_fall = 0;
  int n_checks = 0;
  int n_pass = 0;
  int n_fail = 0;
  int both_cnt = 0;
  logic fd_prev = 1'b0;

  logic [31:0] pv_data_q[$], pv_addr_q[$], pv_cyc_q[$];
  logic [31:0] fd_cnt_q[$], fd_cyc_q[$], fd_err_q[$], fd_ovf_q[$];
  logic [31:0] ovf_next_q[$], err_cyc_q[$];
  logic [23:0] exp_q[$];

  ws2812_rx_decoder #(.NUM_LEDS(N)) dut (
    .CLK(clk), .RESET_N(rst_n), .DIN(din),
    .PIX_VALID(pix_valid), .PIX_DATA(pix_data), .PIX_ADDR(pix_addr),
    .FRAME_DONE(frame_done), .PIX_COUNT(pix_count),
    .OVERFLOW(overflow), .ERROR(error)
  );

  // clock / reset block
  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // monitor: logs output events on the falling edge
  always @(negedge clk) begin
    if (pix_valid) begin
      pv_data_q.push_back(32'(pix_data));
      pv_addr_q.push_back(32'(pix_addr));
      pv_cyc_q.push_back(cyc);
    end
    if (frame_done) begin
      fd_cnt_q.push_back(32'(pix_count));
      fd_cyc_q.push_back(cyc);
      fd_err_q.push_back(32'(error));
      fd_ovf_q.push_back(32'(overflow));
    end
    if (error) err_cyc_q.push_back(cyc);
    if (fd_prev) ovf_next_q.push_back(32'(overflow));
    fd_prev = frame_done;
    if (pix_valid && frame_done) both_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_bit(input int hw, input int lw);
    din = 1'b1;
    tick(hw);
    din = 1'b0;
    last_fall = cyc;
    tick(lw);
  endtask

  task automatic send_pixel(input logic [23:0] v, input int h1, input int h0, input int last_lw);
    int hw;
    int lw;
    for (int i = 23; i >= 0; i--) begin
      hw = v[i] ? h1 : h0;
      lw = (i == 0 && last_lw > 0) ? last_lw : 62 - hw;
      send_bit(hw, lw);
    end
  endtask

  task automatic clear_q();
    pv_data_q.delete(); pv_addr_q.delete(); pv_cyc_q.delete();
    fd_cnt_q.delete(); fd_cyc_q.delete(); fd_err_q.delete(); fd_ovf_q.delete();
    ovf_next_q.delete(); err_cyc_q.delete(); exp_q.delete();
  endtask

  task automatic check_zero_outputs(input string pfx);
    check({pfx, "_pix_valid"}, 32'(pix_valid), 0);
    check({pfx, "_pix_data"}, 32'(pix_data), 0);
    check({pfx, "_pix_addr"}, 32'(pix_addr), 0);
    check({pfx, "_frame_done"}, 32'(frame_done), 0);
    check({pfx, "_pix_count"}, 32'(pix_count), 0);
    check({pfx, "_overflow"}, 32'(overflow), 0);
    check({pfx, "_error"}, 32'(error), 0);
  endtask

  initial begin
    logic [31:0] d, a, c;
    int unsigned f3, f4, r;

    rst_n = 1'b0;
    din = 1'b0;
    tick(4);
    check_zero_outputs("reset");
    rst_n = 1'b1;
    tick(2510);

    // 1: single pixel, latency and frame count
    clear_q();
    send_pixel(24'hA53C0F, 40, 20, 0);
    f3 = last_fall;
    tick(2500);
    check("t1_pv_n", pv_data_q.size(), 1);
    d = pv_data_q.size() > 0 ? pv_data_q.pop_front() : 32'hFFFF_FFFF;
    a = pv_addr_q.size() > 0 ? pv_addr_q.pop_front() : 32'hFFFF_FFFF;
    c = pv_cyc_q.size() > 0 ? pv_cyc_q.pop_front() : 32'hFFFF_FFFF;
    check("t1_data", d, 32'hA53C0F);
    check("t1_addr", a, 0);
    check("t1_latency", c - f3, 4);
    check("t1_fd_n", fd_cnt_q.size(), 1);
    d = fd_cnt_q.size() > 0 ? fd_cnt_q.pop_front() : 32'hFFFF_FFFF;
    check("t1_fd_count", d, 1);
    check("t1_err_n", err_cyc_q.size(), 0);
    check("t1_pix_count_held", 32'(pix_count), 1);

    // 2: ten pixels into an eight-pixel frame
    clear_q();
    for (int v = 1; v <= 10; v++) begin
      send_pixel(24'(v), 40, 20, 0);
      if (v <= N) exp_q.push_back(24'(v));
      if (v == 8) check("t2_ovf_after8", 32'(overflow), 0);
      if (v == 9) check("t2_ovf_after9", 32'(overflow), 1);
    end
    tick(2500);
    check("t2_pv_n", pv_data_q.size(), 8);
    for (int i = 0; i < 8; i++) begin
      d = pv_data_q.size() > 0 ? pv_data_q.pop_front() : 32'hFFFF_FFFF;
      a = pv_addr_q.size() > 0 ? pv_addr_q.pop_front() : 32'hFFFF_FFFF;
      c = exp_q.size() > 0 ? 32'(exp_q.pop_front()) : 32'hEEEE_EEEE;
      check("t2_data", d, c);
      check("t2_addr", a, 32'(i));
    end
    check("t2_fd_n", fd_cnt_q.size(), 1);
    d = fd_cnt_q.size() > 0 ? fd_cnt_q.pop_front() : 32'hFFFF_FFFF;
    check("t2_fd_count", d, 8);
    d = fd_ovf_q.size() > 0 ? fd_ovf_q.pop_front() : 32'hFFFF_FFFF;
    check("t2_ovf_at_fd", d, 1);
    d = ovf_next_q.size() > 0 ? ovf_next_q.pop_front() : 32'hFFFF_FFFF;
    check("t2_ovf_after_fd", d, 0);
    check("t2_pix_count_held", 32'(pix_count), 8);
    check("t2_err_n", err_cyc_q.size(), 0);

    // 3: 29/30-cycle bit threshold, 2499/2500-cycle latch threshold
    // 4: twelve bits then latch -> partial-pixel error with FRAME_DONE
    clear_q();
    send_pixel(24'hF0F0F0, 30, 29, 2499);
    send_pixel(24'h5AC3E1, 40, 20, 2500);
    f3 = last_fall;
    for (int i = 11; i >= 0; i--) begin
      if (((12'hABC >> i) & 12'h1) != 0) send_bit(40, 22);
      else send_bit(20, 42);
    end
    f4 = last_fall;
    tick(2500);
    check("t3_pv_n", pv_data_q.size(), 2);
    d = pv_data_q.size() > 0 ? pv_data_q.pop_front() : 32'hFFFF_FFFF;
    a = pv_addr_q.size() > 0 ? pv_addr_q.pop_front() : 32'hFFFF_FFFF;
    check("t3_thresh_data", d, 32'hF0F0F0);
    check("t3_thresh_addr", a, 0);
    d = pv_data_q.size() > 0 ? pv_data_q.pop_front() : 32'hFFFF_FFFF;
    a = pv_addr_q.size() > 0 ? pv_addr_q.pop_front() : 32'hFFFF_FFFF;
    check("t3_nolatch_data", d, 32'h5AC3E1);
    check("t3_nolatch_addr", a, 1);
    check("t34_fd_n", fd_cnt_q.size(), 2);
    d = fd_cnt_q.size() > 0 ? fd_cnt_q.pop_front() : 32'hFFFF_FFFF;
    c = fd_cyc_q.size() > 0 ? fd_cyc_q.pop_front() : 32'hFFFF_FFFF;
    a = fd_err_q.size() > 0 ? fd_err_q.pop_front() : 32'hFFFF_FFFF;
    check("t3_fd_count", d, 2);
    check("t3_fd_cycle", c, f3 + 2503);
    check("t3_fd_err", a, 0);
    d = fd_cnt_q.size() > 0 ? fd_cnt_q.pop_front() : 32'hFFFF_FFFF;
    c = fd_cyc_q.size() > 0 ? fd_cyc_q.pop_front() : 32'hFFFF_FFFF;
    a = fd_err_q.size() > 0 ? fd_err_q.pop_front() : 32'hFFFF_FFFF;
    check("t4_fd_count", d, 0);
    check("t4_fd_cycle", c, f4 + 2503);
    check("t4_fd_err", a, 1);
    check("t4_err_n", err_cyc_q.size(), 1);
    d = err_cyc_q.size() > 0 ? err_cyc_q.pop_front() : 32'hFFFF_FFFF;
    check("t4_err_cycle", d, c);

    // 5: over-long high mid-pixel, ignored bits, then resync
    clear_q();
    for (int i = 0; i < 10; i++) send_bit(40, 22);
    din = 1'b1;
    r = cyc;
    tick(150);
    din = 1'b0;
    tick(30);
    for (int i = 0; i < 8; i++) send_bit(40, 22);
    tick(2510);
    send_pixel(24'h123456, 40, 20, 0);
    tick(2500);
    check("t5_err_n", err_cyc_q.size(), 1);
    d = err_cyc_q.size() > 0 ? err_cyc_q.pop_front() : 32'hFFFF_FFFF;
    check("t5_err_cycle", d, r + 104);
    check("t5_pv_n", pv_data_q.size(), 1);
    d = pv_data_q.size() > 0 ? pv_data_q.pop_front() : 32'hFFFF_FFFF;
    a = pv_addr_q.size() > 0 ? pv_addr_q.pop_front() : 32'hFFFF_FFFF;
    check("t5_data", d, 32'h123456);
    check("t5_addr", a, 0);
    check("t5_fd_n", fd_cnt_q.size(), 1);
    d = fd_cnt_q.size() > 0 ? fd_cnt_q.pop_front() : 32'hFFFF_FFFF;
    check("t5_fd_count", d, 1);

    // 6: reset pulse after five bits of a pixel
    clear_q();
    for (int i = 0; i < 5; i++) send_bit(40, 22);
    rst_n = 1'b0;
    tick(1);
    check_zero_outputs("t6_reset");
    rst_n = 1'b1;
    for (int i = 0; i < 19; i++) begin
      if ((i % 2) == 0) send_bit(40, 22);
      else send_bit(20, 42);
    end
    tick(2510);
    check("t6_pv_ignored", pv_data_q.size(), 0);
    send_pixel(24'hC0FFEE, 40, 20, 0);
    tick(2500);
    check("t6_pv_n", pv_data_q.size(), 1);
    d = pv_data_q.size() > 0 ? pv_data_q.pop_front() : 32'hFFFF_FFFF;
    a = pv_addr_q.size() > 0 ? pv_addr_q.pop_front() : 32'hFFFF_FFFF;
    check("t6_data", d, 32'hC0FFEE);
    check("t6_addr", a, 0);
    check("t6_fd_n", fd_cnt_q.size(), 1);
    d = fd_cnt_q.size() > 0 ? fd_cnt_q.pop_front() : 32'hFFFF_FFFF;
    check("t6_fd_count", d, 1);
    check("t6_err_n", err_cyc_q.size(), 0);

    check("no_pv_fd_overlap", both_cnt, 0);

    // final report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/ws2812_rx_decoder.md
Name: ws2812_rx_decoder

Overview:
- Decodes a WS2812 single-wire NRZ stream on DIN into 24-bit GRB pixel words, pixel addresses and frame boundaries.
- It is the receiving end of the ws2812 transmitter's DO output.
- Used as an in-fabric loopback checker for the SPI-to-NeoPixel path, and as a front end for daisy-chained capture boards.
- Runs on the 50 MHz system clock and classifies bits by measuring high-pulse width.

Parameters:
NUM_LEDS, 8, pixels accepted per frame; later pixels flagged as overflow
SYSTEM_CLOCK, 50000000, CLK frequency in Hz
T_BIT_THRESH_NS, 600, high pulse >= this is a '1', shorter is a '0'
T_HIGH_MAX_NS, 2000, high pulse longer than this is a protocol error
T_RESET_NS, 50000, low time >= this ends a frame (latch)
Derived: cycles(x) = (SYSTEM_CLOCK/1000000)*x/1000, giving 30 / 100 / 2500 at defaults.

Ports:
CLK  input  1  system clock, all logic on rising edge
RESET_N  input  1  synchronous active-low reset
DIN  input  1  asynchronous WS2812 line
PIX_VALID  output  1  one-cycle strobe; PIX_DATA/PIX_ADDR valid
PIX_DATA  output  24  {G,R,B}, first-received bit in [23]
PIX_ADDR  output  $clog2(NUM_LEDS)  index of pixel within frame
FRAME_DONE  output  1  one-cycle strobe at latch detection
PIX_COUNT  output  $clog2(NUM_LEDS)+1  complete pixels in the frame just ended; valid with FRAME_DONE, held until next FRAME_DONE
OVERFLOW  output  1  sticky per frame: more than NUM_LEDS pixels received
ERROR  output  1  one-cycle strobe: over-long high pulse or partial pixel at latch

Behaviour:
- Reset (RESET_N=0 at a CLK edge): all outputs 0, PIX_COUNT=0, bit/pixel counters 0, state SYNC, sync flops cleared to 0.
- DIN passes through a 2-flop synchronizer, then a registered copy for edge detection. All edge decisions use the synchronized signal.
- FSM:
  - SYNC: line must be low for cycles(T_RESET_NS) consecutive cycles before decoding starts. A high restarts the count. Count complete -> IDLE. No FRAME_DONE is issued on this entry.
  - IDLE/LOW: count low cycles, saturating at the reset count. A rising edge clears the high counter -> HIGH.
  - HIGH: count high cycles, saturating.
    - If the count exceeds cycles(T_HIGH_MAX_NS): ERROR strobe, partial pixel discarded, bit counter cleared -> SYNC.
    - On a falling edge: bit = (high_count >= cycles(T_BIT_THRESH_NS)). Shift bit into the 24-bit shift register (MSB first), increment the bit counter -> LOW.
- On the 24th bit:
  - Bit counter returns to 0.
  - If pixel counter < NUM_LEDS: PIX_VALID=1 for one cycle, PIX_DATA=shift value, PIX_ADDR=pixel counter; pixel counter increments.
  - Otherwise: no PIX_VALID, OVERFLOW set; pixel counter saturates at NUM_LEDS.
- Latch: in LOW, when the low count reaches cycles(T_RESET_NS) and at least one bit has been seen since the last latch:
  - FRAME_DONE=1 for one cycle; PIX_COUNT=pixel counter.
  - If bit counter != 0: ERROR strobe in the same cycle and the partial pixel is discarded.
  - Pixel and bit counters clear. OVERFLOW clears on the cycle after FRAME_DONE.
  - State stays IDLE.
- Latency: PIX_VALID asserts exactly 4 CLK cycles after the DIN falling edge of the 24th bit (2 sync + 1 edge register + 1 output register). FRAME_DONE asserts at the same pipeline offset relative to the cycle the reset threshold is met.
- Boundaries:
  - A high pulse exactly at the threshold count decodes as '1'; one cycle less decodes as '0'.
  - A low exactly equal to cycles(T_RESET_NS) latches; one less does not.
  - A glitch shorter than 1 cycle may be lost. Its effect is defined only by the synchronized waveform.
  - RESET_N deasserted mid-frame: the remainder of that frame is ignored until a full reset-low period is seen (SYNC).
  - PIX_VALID and FRAME_DONE are never asserted in the same cycle, since a latch requires >= 2500 low cycles after the last bit.

Test Plan:
1. Reset, hold DIN low 2500 cycles, then send one pixel 0xA5_3C_0F (T1H=40 cyc, T0H=20 cyc, period 62 cyc), then low 2500 cycles. Required: PIX_VALID once with PIX_DATA=0xA53C0F and PIX_ADDR=0, exactly 4 cycles after the 24th falling edge; FRAME_DONE with PIX_COUNT=1; no ERROR.
2. Send 10 pixels (values 0x000001..0x00000A) with NUM_LEDS=8. Required: 8 PIX_VALID strobes at addresses 0..7 with matching data; OVERFLOW=1 after the 9th pixel; FRAME_DONE with PIX_COUNT=8; OVERFLOW=0 on the following cycle.
3. Threshold sweep with high widths of 29 and 30 cycles. Required: bits decode as 0 and 1 respectively. Low gaps of 2499 and 2500 cycles: no latch and latch respectively.
4. Send 12 bits, then low 2500 cycles. Required: ERROR and FRAME_DONE in the same cycle, PIX_COUNT=0, no PIX_VALID.
5. Hold DIN high for 150 cycles mid-pixel. Required: ERROR strobe after the count passes 100. Subsequent bits are ignored until 2500 low cycles; then a fresh pixel 0x123456 decodes at PIX_ADDR=0.
6. Assert RESET_N=0 for 1 cycle after 5 bits of a pixel. Required: all outputs 0 next cycle; the remaining bits of that frame produce no PIX_VALID; the next frame after a 2500-cycle low decodes correctly.
